pwm_ramp: RTL and testbench
===========================

Name: pwm_ramp

Overview:
- Parametrised ramp-up/ramp-down PWM throttle generator for the motor drive path; successor to the fixed 4-step accelerator.
- Steps duty from 0 to 100% in STEPS equal increments on a start edge and holds at full power.
- Ramps back down on a stop edge; abort kills output immediately.
- Sits between the drive-control FSM and the motor driver pin, clocked from the 1 MHz domain.

Parameters:
PERIOD_US, 100, PWM period in clk_1mhz cycles; must be a multiple of STEPS.
STEPS, 4, number of duty levels; level k gives k/STEPS duty; STEPS >= 1.
STEP_PERIODS, 2500, PWM periods spent at each level during a ramp; >= 1.
(Derived localparams: DUTY_INC = PERIOD_US/STEPS; LVL_W = clog2(STEPS+1).)

Ports:
clk_1mhz  in  1  1 MHz system clock
reset  in  1  asynchronous, active-high reset
start  in  1  ramp-up request; acted on at rising edge
stop  in  1  ramp-down request; acted on at rising edge
abort  in  1  level-sensitive immediate shutdown
pwm_signal  out  1  registered PWM output to motor driver
level  out  LVL_W  current duty level, 0..STEPS
accelerator_active  out  1  high in RAMP_UP or RAMP_DOWN
accelerated  out  1  high while in AT_SPEED
ramp_done  out  1  one-cycle pulse when RAMP_DOWN reaches level 0

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; internal us_cnt, period_cnt, start_prev, stop_prev = 0.
- Edge detect: start_prev/stop_prev registered each cycle. An edge is input=1 with prev=0 at a clock edge.
- us_cnt counts 0..PERIOD_US-1 and wraps while in RAMP_UP, AT_SPEED or RAMP_DOWN. It is held at 0 in IDLE.
- Invariant: pwm_signal == (us_cnt < level*DUTY_INC) for the current register values.
  - level 0 -> constant 0.
  - level STEPS -> constant 1.
- period_cnt increments on each us_cnt wrap. A step ends when period_cnt == STEP_PERIODS-1 and us_cnt == PERIOD_US-1. At step end period_cnt clears.
- IDLE:
  - start edge -> RAMP_UP, level=1, us_cnt=0, period_cnt=0. pwm_signal is 1 on the same edge.
  - stop edge ignored.
- RAMP_UP:
  - At step end with level < STEPS: level+1.
  - At step end with level == STEPS: -> AT_SPEED.
  - Full ramp lasts STEPS*STEP_PERIODS*PERIOD_US cycles.
- AT_SPEED:
  - level=STEPS, pwm_signal=1, accelerated=1.
  - start edge ignored.
  - stop edge -> RAMP_DOWN with level=STEPS-1 (if STEPS==1: -> IDLE, level 0, ramp_done pulse).
- RAMP_DOWN:
  - At step end: level-1.
  - When level reaches 0 -> IDLE, pwm_signal=0, ramp_done=1 for exactly that one cycle.
- Stop edge in RAMP_UP: -> RAMP_DOWN, level-1, us_cnt=0, period_cnt=0. If level was 1: -> IDLE directly with ramp_done pulse.
- Start edge in RAMP_DOWN: -> RAMP_UP, level+1, counters cleared.
- Simultaneous start and stop edges: stop wins.
- abort=1 in any state, evaluated before edges: next edge forces IDLE with level 0, pwm_signal 0, counters 0, accelerated 0. No ramp_done pulse.
  - While abort is held, start edges are ignored. The edge registers still track, so a start held high through abort release does not trigger.
- Mid-operation async reset: outputs drop to 0 immediately, without waiting for a clock edge.
- Counters never overflow. Level is saturated to 0..STEPS by the state machine.

Test Plan:
All scenarios use bench parameters PERIOD_US=8, STEPS=4, STEP_PERIODS=2.
- Reset then start pulse -> accelerator_active=1 next edge; level1 pwm high 2 of 8 cycles; levels 2/3/4 give 4/6/8 high; accelerated=1 exactly 64 cycles after start edge; pwm constant 1 thereafter.
- In AT_SPEED, stop pulse -> levels 3,2,1 each for 16 cycles (duty 6,4,2 of 8); then level 0, pwm 0, ramp_done high one cycle, accelerator_active 0.
- Stop edge while in RAMP_UP at level 2 -> level 1 next edge, 16 cycles later IDLE with ramp_done pulse. Start edge during that RAMP_DOWN at level 1 -> level 2, RAMP_UP.
- start and stop rising on the same cycle from AT_SPEED -> RAMP_DOWN level 3. The same pair from IDLE -> remains IDLE, all outputs 0.
- abort asserted mid RAMP_UP at level 3 -> next edge pwm 0, level 0, no ramp_done. start held high across abort release -> no new ramp until start toggles.
- Async reset asserted between clock edges during AT_SPEED -> pwm_signal, accelerated, level go 0 before next edge. Counters restart cleanly on the next start.

Source files
------------

// File: rtl/pwm_ramp.sv
// Ramped PWM throttle: steps duty up in STEPS equal increments on start,
// holds at full power, ramps back down on stop; abort forces idle at once.
module pwm_ramp #(
  parameter int PERIOD_US    = 100,
  parameter int STEPS        = 4,
  parameter int STEP_PERIODS = 2500,
  localparam int LVL_W       = $clog2(STEPS + 1)
) (
  input  logic             clk_1mhz,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic             pwm_signal,
  output logic [LVL_W-1:0] level,
  output logic             accelerator_active,
  output logic             accelerated,
  output logic             ramp_done
);
  localparam int DUTY_INC = PERIOD_US / STEPS;
  localparam int US_W     = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
  localparam int PER_W    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

  localparam logic [US_W-1:0]  US_MAX  = US_W'(PERIOD_US - 1);
  localparam logic [PER_W-1:0] PER_MAX = PER_W'(STEP_PERIODS - 1);
  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(STEPS);
  localparam logic [LVL_W-1:0] LVL_ONE = LVL_W'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_AT   = 2'd2;
  localparam logic [1:0] S_DN   = 2'd3;

  logic [1:0]       r_state;
  logic [LVL_W-1:0] r_level;
  logic [US_W-1:0]  r_us_cnt;
  logic [PER_W-1:0] r_period_cnt;
  logic             r_start_prev, r_stop_prev;
  logic             r_pwm, r_done;

  logic [1:0]       w_state_n;
  logic [LVL_W-1:0] w_level_n;
  logic [US_W-1:0]  w_us_n;
  logic [PER_W-1:0] w_per_n;
  logic             w_done_n, w_pwm_n;
  logic             w_start_edge, w_stop_edge, w_us_wrap, w_step_end;

  assign w_start_edge = start & ~r_start_prev;
  assign w_stop_edge  = stop & ~r_stop_prev;
  assign w_us_wrap    = (r_us_cnt == US_MAX);
  assign w_step_end   = w_us_wrap && (r_period_cnt == PER_MAX);

  always_comb begin
    w_state_n = r_state;
    w_level_n = r_level;
    w_done_n  = 1'b0;
    w_us_n    = '0;
    w_per_n   = '0;
    if (r_state != S_IDLE) begin
      w_us_n  = w_us_wrap ? '0 : r_us_cnt + US_W'(1);
      w_per_n = w_us_wrap ? ((r_period_cnt == PER_MAX) ? '0 : r_period_cnt + PER_W'(1))
                          : r_period_cnt;
    end
    // Abort outranks every edge; the default counter values above are
    // overridden wherever a transition restarts the step timing.
    if (abort) begin
      w_state_n = S_IDLE;
      w_level_n = '0;
      w_us_n    = '0;
      w_per_n   = '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start_edge && !w_stop_edge) begin
          w_state_n = S_UP;
          w_level_n = LVL_ONE;
        end
        S_UP: begin
          if (w_stop_edge) begin
            w_us_n  = '0;
            w_per_n = '0;
            if (r_level == LVL_ONE) begin
              w_state_n = S_IDLE;
              w_level_n = '0;
              w_done_n  = 1'b1;
            end else begin
              w_state_n = S_DN;
              w_level_n = r_level - LVL_ONE;
            end
          end else if (w_step_end) begin
            if (r_level == LVL_MAX) w_state_n = S_AT;
            else                    w_level_n = r_level + LVL_ONE;
          end
        end
        S_AT: if (w_stop_edge) begin
          w_us_n  = '0;
          w_per_n = '0;
          if (STEPS == 1) begin
            w_state_n = S_IDLE;
            w_level_n = '0;
            w_done_n  = 1'b1;
          end else begin
            w_state_n = S_DN;
            w_level_n = LVL_MAX - LVL_ONE;
          end
        end
        default: begin
          if (w_start_edge && !w_stop_edge) begin
            w_state_n = S_UP;
            w_level_n = r_level + LVL_ONE;
            w_us_n    = '0;
            w_per_n   = '0;
          end else if (w_step_end) begin
            w_level_n = r_level - LVL_ONE;
            if (r_level == LVL_ONE) begin
              w_state_n = S_IDLE;
              w_done_n  = 1'b1;
              w_us_n    = '0;
            end
          end
        end
      endcase
    end
  end

  // The PWM flop is loaded from next-state values so it always matches
  // the comparison of the registered counter and level.
  assign w_pwm_n = (32'(w_us_n) < 32'(w_level_n) * 32'(DUTY_INC));

  always_ff @(posedge clk_1mhz or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_level      <= '0;
      r_us_cnt     <= '0;
      r_period_cnt <= '0;
      r_start_prev <= 1'b0;
      r_stop_prev  <= 1'b0;
      r_pwm        <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_level      <= w_level_n;
      r_us_cnt     <= w_us_n;
      r_period_cnt <= w_per_n;
      r_start_prev <= start;
      r_stop_prev  <= stop;
      r_pwm        <= w_pwm_n;
      r_done       <= w_done_n;
    end
  end

  assign pwm_signal         = r_pwm;
  assign level              = r_level;
  assign accelerator_active = (r_state == S_UP) || (r_state == S_DN);
  assign accelerated        = (r_state == S_AT);
  assign ramp_done          = r_done;
endmodule

// File: tb/tb_pwm_ramp.sv
// Directed bench for pwm_ramp with PERIOD_US=8, STEPS=4, STEP_PERIODS=2.
module tb_pwm_ramp;
  logic       clk_1mhz = 1'b0;
  logic       reset, start, stop, abort;
  logic       pwm_signal, accelerator_active, accelerated, ramp_done;
  logic [2:0] level;
  int         n_tests = 0;
  int         n_fail  = 0;

  pwm_ramp #(.PERIOD_US(8), .STEPS(4), .STEP_PERIODS(2)) dut (
    .clk_1mhz(clk_1mhz), .reset(reset), .start(start), .stop(stop), .abort(abort),
    .pwm_signal(pwm_signal), .level(level), .accelerator_active(accelerator_active),
    .accelerated(accelerated), .ramp_done(ramp_done)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  task automatic tick();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outs(input string tag, input logic p, input logic [2:0] l,
                          input logic act, input logic acc, input logic d);
    chk({tag, ".pwm"},  {31'd0, pwm_signal}, {31'd0, p});
    chk({tag, ".lvl"},  {29'd0, level}, {29'd0, l});
    chk({tag, ".act"},  {31'd0, accelerator_active}, {31'd0, act});
    chk({tag, ".acc"},  {31'd0, accelerated}, {31'd0, acc});
    chk({tag, ".done"}, {31'd0, ramp_done}, {31'd0, d});
  endtask

  // Samples 8*nwin cycles starting at the current one; checks level at each
  // window start and high count per window; leaves sim 8*nwin cycles later.
  task automatic windows(input string tag, input int nwin, input int exp_lvl[8],
                         input int exp_hi[8], output logic acc_seen, output logic done_seen);
    int hi;
    acc_seen  = 1'b0;
    done_seen = 1'b0;
    for (int w = 0; w < nwin; w++) begin
      hi = 0;
      for (int i = 0; i < 8; i++) begin
        if (i == 0) chk($sformatf("%s.lvl%0d", tag, w), {29'd0, level}, 32'(exp_lvl[w]));
        hi        += int'(pwm_signal);
        acc_seen  |= accelerated;
        done_seen |= ramp_done;
        tick();
      end
      chk($sformatf("%s.hi%0d", tag, w), 32'(hi), 32'(exp_hi[w]));
    end
  endtask

  initial begin
    logic acc_seen, done_seen, all_hi;
    int up_lvl[8] = '{1, 1, 2, 2, 3, 3, 4, 4};
    int up_hi[8]  = '{2, 2, 4, 4, 6, 6, 8, 8};
    int dn_lvl[8] = '{3, 3, 2, 2, 1, 1, 0, 0};
    int dn_hi[8]  = '{6, 6, 4, 4, 2, 2, 0, 0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0;
    ticks(2);
    chk_outs("reset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    tick();
    chk_outs("idle", 0, 0, 0, 0, 0);

    // Full ramp up
    start = 1'b1; tick(); start = 1'b0;
    chk_outs("start", 1, 1, 1, 0, 0);
    windows("up", 8, up_lvl, up_hi, acc_seen, done_seen);
    chk("up.noacc", {31'd0, acc_seen}, 32'd0);
    chk_outs("atspeed", 1, 4, 0, 1, 0);
    all_hi = 1'b1;
    for (int i = 0; i < 10; i++) begin all_hi &= pwm_signal; tick(); end
    chk("at.pwm1", {31'd0, all_hi}, 32'd1);

    // Ramp down from AT_SPEED
    stop = 1'b1; tick(); stop = 1'b0;
    chk_outs("stop", 1, 3, 1, 0, 0);
    windows("dn", 6, dn_lvl, dn_hi, acc_seen, done_seen);
    chk("dn.nodone", {31'd0, done_seen}, 32'd0);
    chk_outs("dn.end", 0, 0, 0, 0, 1);
    tick();
    chk_outs("dn.after", 0, 0, 0, 0, 0);

    // Stop during RAMP_UP at level 2
    start = 1'b1; tick(); start = 1'b0;
    ticks(16);
    chk("up2.lvl", {29'd0, level}, 32'd2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk_outs("upstop", 1, 1, 1, 0, 0);
    ticks(15);
    chk_outs("upstop.15", 0, 1, 1, 0, 0);
    tick();
    chk_outs("upstop.end", 0, 0, 0, 0, 1);
    tick();

    // Start during RAMP_DOWN at level 1
    start = 1'b1; tick(); start = 1'b0;
    ticks(16);
    stop = 1'b1; tick(); stop = 1'b0;
    ticks(3);
    start = 1'b1; tick(); start = 1'b0;
    chk_outs("dnstart", 1, 2, 1, 0, 0);
    ticks(16);
    chk_outs("dnstart.up", 1, 3, 1, 0, 0);

    // Abort mid RAMP_UP at level 3, start held high across release
    ticks(5);
    abort = 1'b1; start = 1'b1; tick();
    chk_outs("abort", 0, 0, 0, 0, 0);
    done_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin done_seen |= ramp_done; tick(); end
    abort = 1'b0;
    for (int i = 0; i < 4; i++) begin done_seen |= ramp_done | accelerator_active; tick(); end
    chk("abort.quiet", {31'd0, done_seen}, 32'd0);
    chk_outs("abort.held", 0, 0, 0, 0, 0);
    start = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    chk_outs("abort.restart", 1, 1, 1, 0, 0);

    // Simultaneous start+stop from AT_SPEED, then from IDLE
    ticks(64);
    chk("sim.at", {31'd0, accelerated}, 32'd1);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk_outs("sim.at", 1, 3, 1, 0, 0);
    abort = 1'b1; tick(); abort = 1'b0; tick();
    start = 1'b1; stop = 1'b1; tick();
    chk_outs("sim.idle", 0, 0, 0, 0, 0);
    start = 1'b0; stop = 1'b0; tick();
    chk_outs("sim.idle2", 0, 0, 0, 0, 0);

    // Async reset mid-cycle in AT_SPEED
    start = 1'b1; tick(); start = 1'b0;
    ticks(64);
    chk_outs("pre.rst", 1, 4, 0, 1, 0);
    #2 reset = 1'b1;
    #1 chk_outs("async.rst", 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk_outs("rst.restart", 1, 1, 1, 0, 0);
    windows("rst.up", 2, up_lvl, up_hi, acc_seen, done_seen);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
